// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and slice/group geometry for the ALU slice engine
package alu_pkg;

  localparam int SLICE_W          = 4;
  localparam int GROUP_W          = 16;
  localparam int SLICES_PER_GROUP = GROUP_W / SLICE_W;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_PASSA = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // ADD and SUB share the adder path (SUB arrives with b already inverted)
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu4_slice.sv
// rtl/alu4_slice.sv - 4-bit ALU slice with active-low group generate/propagate
module alu4_slice
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic [2:0]         op_i,
  input  logic               c_i,
  output logic [SLICE_W-1:0] f_o,
  output logic               g_n_o,
  output logic               p_n_o
);

  logic [SLICE_W-1:0] gen_bits;
  logic [SLICE_W-1:0] prop_bits;
  logic               grp_g;

  assign gen_bits  = a_i & b_i;
  assign prop_bits = a_i ^ b_i;

  // Slice generate/propagate depend only on operands, never on c_i, so the
  // lookahead in the engine has no combinational path back through a slice
  always_comb begin
    grp_g = 1'b0;
    for (int i = 0; i < SLICE_W; i++) begin
      grp_g = gen_bits[i] | (prop_bits[i] & grp_g);
    end
    g_n_o = 1'b1;
    p_n_o = 1'b1;
    if (is_arith(op_i)) begin
      g_n_o = ~grp_g;
      p_n_o = ~(&prop_bits);
    end
  end

  // Function output; 11x opcodes yield zero
  always_comb begin
    f_o = '0;
    case (op_i)
      OP_ADD, OP_SUB: f_o = a_i + b_i + {{(SLICE_W-1){1'b0}}, c_i};
      OP_AND:         f_o = a_i & b_i;
      OP_OR:          f_o = a_i | b_i;
      OP_XOR:         f_o = a_i ^ b_i;
      OP_PASSA:       f_o = a_i;
      default:        f_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_slice_engine.sv
// rtl/alu_slice_engine.sv - multi-cycle bit-sliced ALU, one 16-bit group per cycle; ALU_OVF_FLAG_EN adds signed overflow output ovf
module alu_slice_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NGROUPS = WIDTH / GROUP_W;
  localparam int IDXW    = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int GSH     = $clog2(GROUP_W);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NGROUPS - 1);

  if (((WIDTH % GROUP_W) != 0) || (WIDTH < GROUP_W)) begin : g_width_chk
    $error("alu_slice_engine: WIDTH must be a non-zero multiple of 16");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
`ifdef ALU_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
  logic             c_msb;
`endif

  logic [IDXW+GSH-1:0]         base;
  logic [GROUP_W-1:0]          grp_a, grp_b, grp_f;
  logic [SLICES_PER_GROUP-1:0] g_n, p_n;
  logic [SLICES_PER_GROUP:0]   c;

  assign base  = {idx_q, {GSH{1'b0}}};
  assign grp_a = a_q[base +: GROUP_W];
  assign grp_b = b_q[base +: GROUP_W];

  for (genvar j = 0; j < SLICES_PER_GROUP; j++) begin : g_slice
    alu4_slice u_slice (
      .a_i   (grp_a[j*SLICE_W +: SLICE_W]),
      .b_i   (grp_b[j*SLICE_W +: SLICE_W]),
      .op_i  (op_q),
      .c_i   (c[j]),
      .f_o   (grp_f[j*SLICE_W +: SLICE_W]),
      .g_n_o (g_n[j]),
      .p_n_o (p_n[j])
    );
  end

  // Group lookahead: slice carries from active-low G/P, seeded by the rippled carry
  always_comb begin
    c    = '0;
    c[0] = carry_q;
    for (int j = 0; j < SLICES_PER_GROUP; j++) begin
      c[j+1] = ~g_n[j] | (~p_n[j] & c[j]);
    end
  end

`ifdef ALU_OVF_FLAG_EN
  // Carry into the top bit recovered from its sum: a ^ b ^ f
  assign c_msb = grp_a[GROUP_W-1] ^ grp_b[GROUP_W-1] ^ grp_f[GROUP_W-1];
`endif

  // Next-state and datapath update; zero is evaluated over the completed
  // result in the first DONE cycle, so out_valid rises one cycle later
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    valid_d  = valid_q;
`ifdef ALU_OVF_FLAG_EN
    ovf_d    = ovf_q;
`endif
    in_ready = (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = (op == OP_SUB) ? ~b : b;
          op_d    = op;
          carry_d = (op == OP_SUB) ? 1'b1 : cin;
          idx_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        result_d[base +: GROUP_W] = grp_f;
        carry_d = c[SLICES_PER_GROUP];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = is_arith(op_q) & c[SLICES_PER_GROUP];
`ifdef ALU_OVF_FLAG_EN
          ovf_d   = is_arith(op_q) & (c_msb ^ c[SLICES_PER_GROUP]);
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!valid_q) begin
          zero_d  = ~(|result_q);
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
`ifdef ALU_OVF_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
`ifdef ALU_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_slice_engine.sv
// tb/tb_alu_slice_engine.sv - table-driven bench for alu_slice_engine (checks ovf when ALU_OVF_FLAG_EN is defined)
module tb_alu_slice_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        zero;
`ifdef ALU_OVF_FLAG_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] res;
    logic        co;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  alu_slice_engine #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero)
`ifdef ALU_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void add_vec(input string name, input logic [2:0] vop, input logic [31:0] va,
                                  input logic [31:0] vb, input logic vcin, input logic [31:0] vres,
                                  input logic vco, input logic vz, input logic vov);
    vec_t v;
    v.name = name; v.op = vop; v.a = va; v.b = vb; v.cin = vcin;
    v.res = vres; v.co = vco; v.z = vz; v.ov = vov;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request for a single cycle; called #1 after a rising edge while IDLE
  task automatic start_op(input string name, input logic [2:0] vop, input logic [31:0] va,
                          input logic [31:0] vb, input logic vcin);
    check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = vop; a = va; b = vb; cin = vcin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = ~vcin; op = 3'($urandom_range(0, 7));
  endtask

  // Wait (bounded) for out_valid after the accept edge and check the latency
  task automatic wait_valid(input string name);
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'd3);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    start_op(v.name, v.op, v.a, v.b, v.cin);
    wait_valid(v.name);
    check({v.name, " result"}, result, v.res);
    check({v.name, " cout"}, 32'(cout), 32'(v.co));
    check({v.name, " zero"}, 32'(zero), 32'(v.z));
    check({v.name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
`ifdef ALU_OVF_FLAG_EN
    check({v.name, " ovf"}, 32'(ovf), 32'(v.ov));
`endif
    handshake(v.name);
  endtask

  initial begin
    //       name         op      a             b             cin   result        co    z     ov
    add_vec("add_carry16", 3'b000, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    add_vec("sub_borrow",  3'b001, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    add_vec("sub_equal",   3'b001, 32'h0000_0007, 32'h0000_0007, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    add_vec("add_ovf",     3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    add_vec("xor",         3'b100, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0);
    add_vec("illegal110",  3'b110, 32'h0000_FFFF, 32'h0000_1234, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    add_vec("add_cin_wrap",3'b000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    add_vec("and_cin1",    3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 32'h00F0_1234, 1'b0, 1'b0, 1'b0);
    add_vec("or",          3'b011, 32'h1200_0034, 32'h0000_5600, 1'b0, 32'h1200_5634, 1'b0, 1'b0, 1'b0);
    add_vec("passa",       3'b101, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    add_vec("sub_cin0",    3'b001, 32'h0000_000A, 32'h0000_0003, 1'b0, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
    add_vec("illegal111",  3'b111, 32'h8000_0001, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    add_vec("add_negovf",  3'b000, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    add_vec("add_cin1",    3'b000, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
    add_vec("sub_0m1",     3'b001, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    add_vec("sub_minovf",  3'b001, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'h0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
`ifdef ALU_OVF_FLAG_EN
    check("reset ovf", 32'(ovf), 32'd0);
`endif

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: DONE holds while out_ready is low; in_valid pulses are dropped
    start_op("hold", 3'b000, 32'h0000_0001, 32'h0000_0002, 1'b0);
    wait_valid("hold");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = $urandom; b = $urandom; op = 3'b000;
      @(posedge clk); #1;
      check("hold result", result, 32'h0000_0003);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    handshake("hold");
    check("hold in_ready after release", 32'(in_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("hold no queued op", 32'(out_valid), 32'd0);
    check("hold still idle", 32'(in_ready), 32'd1);

    // Reset in the middle of CALC discards the operation
    start_op("midrst", 3'b000, 32'h0005_0005, 32'h0006_0006, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst result", result, 32'h0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst cout", 32'(cout), 32'd0);
    check("midrst zero", 32'(zero), 32'd0);
    start_op("postrst", 3'b000, 32'h0000_0001, 32'h0000_0001, 1'b0);
    wait_valid("postrst");
    check("postrst result", result, 32'h0000_0002);
    check("postrst cout", 32'(cout), 32'd0);
    check("postrst zero", 32'(zero), 32'd0);
    handshake("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
